// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash-style responder over a small 32-bit word memory (read 0x03, write 0x02).
// Define SPI_RESP_WEL_EN to add a write-enable latch (0x06) that gates 0x02 writes.
module spi_flash_responder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int SCK_SYNC   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic SCK,
    input  logic CS,
    input  logic DI,
    output logic DO,
    output logic DOE,
    output logic busy,
    output logic wrPulse,
    output logic errCmd
);
    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_WREN  = 8'h06;
`ifdef SPI_RESP_WEL_EN
    localparam bit         WEL_EN   = 1'b1;
`else
    localparam bit         WEL_EN   = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, WR_DATA, IGNORE} state_t;

    state_t                      state, state_nxt;
    logic [SCK_SYNC-1:0]         sck_sync, cs_sync, di_sync;
    logic [SCK_SYNC:0]           vld_pipe;
    logic                        sck_s, cs_s, di_s, sck_d, cs_d, cs_seen_hi;
    logic                        sck_rise, sck_fall, cs_fall, cs_rise;
    logic                        cmd_done, addr_done, err_nxt, commit, wel_ok;
    logic [5:0]                  cnt;
    logic [30:0]                 shreg;
    logic [31:0]                 oshift;
    logic [7:0]                  opcode, opc;
    logic [DEPTH_LOG2-1:0]       idx, idx_inc, addr_idx;
    logic [DEPTH-1:0][31:0]      mem;

    assign sck_s = sck_sync[SCK_SYNC-1];
    assign cs_s  = cs_sync[SCK_SYNC-1];
    assign di_s  = di_sync[SCK_SYNC-1];

    // SCK edges only count while CS is low; a CS fall is only accepted once CS
    // has been seen high after reset, so a reset released mid-transfer stays idle.
    assign sck_rise = ~cs_s & sck_s & ~sck_d;
    assign sck_fall = ~cs_s & ~sck_s & sck_d;
    assign cs_fall  = cs_seen_hi & cs_d & ~cs_s;
    assign cs_rise  = cs_s & ~cs_d;

    assign opc      = {shreg[6:0], di_s};
    assign addr_idx = shreg[DEPTH_LOG2:1];
    assign idx_inc  = idx + DEPTH_LOG2'(1);
    assign commit   = (state == WR_DATA) && sck_rise && (cnt == 6'd31) && !cs_fall;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sync   <= '0;
            cs_sync    <= '1;
            di_sync    <= '0;
            sck_d      <= 1'b0;
            cs_d       <= 1'b1;
            cs_seen_hi <= 1'b0;
            vld_pipe   <= '0;
        end else begin
            sck_sync <= {sck_sync[SCK_SYNC-2:0], SCK};
            cs_sync  <= {cs_sync[SCK_SYNC-2:0], CS};
            di_sync  <= {di_sync[SCK_SYNC-2:0], DI};
            sck_d    <= sck_s;
            cs_d     <= cs_s;
            vld_pipe <= {vld_pipe[SCK_SYNC-1:0], 1'b1};
            if (vld_pipe[SCK_SYNC] && cs_s) cs_seen_hi <= 1'b1;
        end
    end

`ifdef SPI_RESP_WEL_EN
    logic wel;
    assign wel_ok = wel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                 wel <= 1'b0;
        else if (cs_rise && opcode == OP_WRITE)   wel <= 1'b0;
        else if (cmd_done && opc == OP_WREN)      wel <= 1'b1;
    end
`else
    assign wel_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // CS fall outranks everything, so a coincident SCK edge is never counted.
    always_comb begin
        state_nxt = state;
        cmd_done  = 1'b0;
        addr_done = 1'b0;
        err_nxt   = 1'b0;
        if (cs_fall) begin
            state_nxt = CMD;
        end else if (cs_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                CMD: if (sck_rise && cnt == 6'd7) begin
                    cmd_done = 1'b1;
                    if (opc == OP_READ || (opc == OP_WRITE && wel_ok)) begin
                        state_nxt = ADDR;
                    end else begin
                        state_nxt = IGNORE;
                        err_nxt   = !(WEL_EN && opc == OP_WREN);
                    end
                end
                ADDR: if (sck_rise && cnt == 6'd23) begin
                    addr_done = 1'b1;
                    state_nxt = (opcode == OP_READ) ? RD_DATA : WR_DATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            shreg   <= '0;
            oshift  <= '0;
            opcode  <= '0;
            idx     <= '0;
            mem     <= '0;
            DO      <= 1'b0;
            DOE     <= 1'b0;
            wrPulse <= 1'b0;
            errCmd  <= 1'b0;
        end else begin
            wrPulse <= commit;
            errCmd  <= err_nxt;

            if (cs_fall || state_nxt != state)
                cnt <= '0;
            else if ((state == RD_DATA && sck_fall) || (state == WR_DATA && sck_rise))
                cnt <= (cnt == 6'd31) ? 6'd0 : cnt + 6'd1;
            else if ((state == CMD || state == ADDR) && sck_rise)
                cnt <= cnt + 6'd1;

            if (sck_rise && !cs_fall) shreg <= {shreg[29:0], di_s};

            if (cs_fall)       opcode <= '0;
            else if (cmd_done) opcode <= opc;

            if (addr_done) begin
                idx <= addr_idx;
            end else if (commit) begin
                mem[idx] <= {shreg, di_s};
                idx      <= idx_inc;
            end else if (state == RD_DATA && state_nxt == RD_DATA && sck_fall && cnt == 6'd31) begin
                idx <= idx_inc;
            end

            // Read words stream back to back: the fall that shifts out bit 0
            // also preloads the next word, so its bit 31 follows on the next fall.
            if (state_nxt != RD_DATA) begin
                DOE <= 1'b0;
                DO  <= 1'b0;
            end else if (state != RD_DATA) begin
                DOE    <= 1'b1;
                oshift <= mem[addr_idx];
            end else if (sck_fall) begin
                DO     <= oshift[31];
                oshift <= (cnt == 6'd31) ? mem[idx_inc] : {oshift[30:0], 1'b0};
            end
        end
    end
endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving log2 of the number of 32-bit storage words.
REQ-002 SHALL have parameter SCK_SYNC, default 2, giving the number of synchroniser flops on SCK, CS and DI (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: single system clock; every flop is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port SCK, input, 1 bit: SPI serial clock from the initiator, mode 0.
REQ-006 SHALL have port CS, input, 1 bit: chip select, active-low.
REQ-007 SHALL have port DI, input, 1 bit: serial data from the initiator, MSB first.
REQ-008 SHALL have port DO, output, 1 bit: serial data to the initiator, MSB first.
REQ-009 SHALL have port DOE, output, 1 bit: high while DO carries valid read data.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 SHALL have port wrPulse, output, 1 bit: one-clk pulse on each committed word write.
REQ-012 SHALL have port errCmd, output, 1 bit: one-clk pulse when an unsupported opcode is received.

Function
REQ-013 SHALL pass SCK, CS and DI through SCK_SYNC flops, then detect SCK rise and fall edges on the synchronised copies; clk SHALL be at least 8x the SCK frequency.
REQ-014 SHALL sample DI on synchronised SCK rising edges and update DO on synchronised SCK falling edges.
REQ-015 SHALL implement FSM states IDLE, CMD, ADDR, RD_DATA, WR_DATA and IGNORE, with a 6-bit bit counter cleared on every state entry.
REQ-016 SHALL move IDLE->CMD on the synchronised CS falling edge.
REQ-017 SHALL, in CMD after 8 bits: opcode 0x03 or 0x02 -> ADDR; opcode 0x06 -> IGNORE (handled per REQ-030); any other opcode -> IGNORE with errCmd pulsed.
REQ-018 SHALL, in ADDR after 24 bits, latch the word index as addr[DEPTH_LOG2+1:2]; addr[1:0] and upper bits are ignored; then read -> RD_DATA, write -> WR_DATA.
REQ-019 SHALL, on RD_DATA entry, load the 32-bit output shifter from mem[index] and raise DOE; DO SHALL present bit31 after the first SCK falling edge that follows the final address bit.
REQ-020 SHALL, after 32 read bits, increment index modulo 2^DEPTH_LOG2, reload the shifter and continue with no gap.
REQ-021 SHALL, in WR_DATA, commit the shifted word to mem[index] with wrPulse when the 32nd bit is sampled, then increment index with wrap.
REQ-022 SHALL, on a CS rising edge in any state, return to IDLE within 1 clk, clear DOE and drive DO=0; a partially shifted write word is discarded with no write and no wrPulse.
REQ-023 SHALL ignore SCK edges while CS is high, and SHALL drop all bits in IGNORE until CS rises.
REQ-024 SHALL apply CS-fall priority over a coincident SCK edge: the state is reset first and that edge is not counted.
REQ-025 SHALL keep DO=0 whenever DOE=0.

Reset
REQ-026 SHALL, while rst=0, force state=IDLE, counter=0, DO=0, DOE=0, busy=0, wrPulse=0 and errCmd=0, and clear all memory words to 0.
REQ-027 SHALL honour a reset asserted mid-transfer immediately; after release, SHALL wait for a fresh CS falling edge before accepting a command.
REQ-028 SHALL initialise the synchroniser flops to SCK=0, CS=1, DI=0.

Configuration
REQ-029 SHALL define feature macro SPI_RESP_WEL_EN.
REQ-030 SHALL, when SPI_RESP_WEL_EN is defined, implement a write-enable latch WEL with reset value 0: opcode 0x06 sets WEL; a 0x02 write with WEL=0 goes to IGNORE with errCmd pulsed; WEL clears at the CS rise that ends any 0x02 transfer.
REQ-031 SHALL, when SPI_RESP_WEL_EN is undefined, omit WEL, always accept 0x02, and treat 0x06 as unsupported (errCmd pulsed).

Verification
REQ-032 SHALL cover: write 0x02, addr 0x000004, data 0xDEADBEEF -> one wrPulse; read 0x03, addr 0x000004 -> DO returns 0xDEADBEEF with DOE high for 32 bits.
REQ-033 SHALL cover: read at addr 0x00003C with DEPTH_LOG2=4 for 64 bits -> mem[15] then mem[0].
REQ-034 SHALL cover: CS raised after 20 write data bits -> no wrPulse; a read of the same address returns the old value.
REQ-035 SHALL cover: opcode 0xAB -> one errCmd pulse, DOE stays 0, busy stays high until CS rises.
REQ-036 SHALL cover: rst pulsed low mid-read -> DO=0, DOE=0 and busy=0 immediately; a full read after release returns 0x00000000.
REQ-037 SHALL cover, with SPI_RESP_WEL_EN defined: 0x02 write without a preceding 0x06 -> errCmd pulse and no write; 0x06 then 0x02 -> write committed.
